// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-serial RAM port between instruction fetch (IF)
// and load/store (MEM). It accepts one request at a time, issues it with a
// single mc_req pulse, waits for mc_done and then returns the result to the
// requester that owns the transaction with a one-cycle done pulse.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              flush,
    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_inst,
    // load/store side
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_mask,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_rdata,
    // memory controller side
    output logic              mc_req,
    output logic              mc_we,
    output logic [1:0]        mc_mask,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata,
    // stall requests
    output logic              stall_if,
    output logic              stall_mem
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_GRANT_IF  = 3'd1;
    localparam logic [2:0] S_WAIT_IF   = 3'd2;
    localparam logic [2:0] S_GRANT_MEM = 3'd3;
    localparam logic [2:0] S_WAIT_MEM  = 3'd4;
    localparam logic [2:0] S_RESP      = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              resp_mem;     // transaction in flight belongs to MEM
    logic              discard;      // flushed fetch: complete downstream, drop result
    logic [DATA_W-1:0] rdata_q;      // result captured on mc_done
    logic [DATA_W-1:0] if_inst_q;
    logic [DATA_W-1:0] mem_rdata_q;
    logic [DATA_W-1:0] wdata_masked;
    logic              mem_valid;

    assign mem_valid = mem_req & (mem_mask != 2'b00);

    // Clear store-data bits above the access width so the controller never sees stale upper bytes.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
        wdata_masked = mem_wdata;
        case (mem_mask)
            2'b01:   wdata_masked = {{(DATA_W-8){1'b0}}, mem_wdata[7:0]};
            2'b10:   wdata_masked = {{(DATA_W-16){1'b0}}, mem_wdata[15:0]};
            default: wdata_masked = mem_wdata;
        endcase
    end

    // Next-state logic: MEM has fixed priority in IDLE; a flush blocks a new fetch grant.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (mem_valid)
                    state_nxt = S_GRANT_MEM;
                else if (if_req && !flush)
                    state_nxt = S_GRANT_IF;
            end
            S_GRANT_IF:  state_nxt = S_WAIT_IF;
            S_GRANT_MEM: state_nxt = S_WAIT_MEM;
            S_WAIT_IF:   if (mc_done) state_nxt = S_RESP;
            S_WAIT_MEM:  if (mc_done) state_nxt = S_RESP;
            S_RESP:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Pulses are qualified by rdy_in so a frozen arbiter emits nothing and a GRANT re-pulses on resume.
    // A flush seen during RESP-for-IF suppresses that same-cycle if_done.
    assign mc_req    = rdy_in & ((state == S_GRANT_IF) | (state == S_GRANT_MEM));
    assign if_done   = rdy_in & (state == S_RESP) & ~resp_mem & ~discard & ~flush;
    assign mem_done  = rdy_in & (state == S_RESP) & resp_mem;
    assign if_inst   = if_done  ? rdata_q : if_inst_q;
    assign mem_rdata = mem_done ? rdata_q : mem_rdata_q;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_valid & ~mem_done;

    // State, request latches, capture and result registers; everything holds while rdy_in is low.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= S_IDLE;
            resp_mem    <= 1'b0;
            discard     <= 1'b0;
            rdata_q     <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            mc_we       <= 1'b0;
            mc_mask     <= 2'b00;
            mc_addr     <= '0;
            mc_wdata    <= '0;
        end else if (rdy_in) begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (mem_valid) begin
                        mc_we    <= mem_we;
                        mc_mask  <= mem_mask;
                        mc_addr  <= mem_addr;
                        mc_wdata <= wdata_masked;
                        resp_mem <= 1'b1;
                    end else if (if_req && !flush) begin
                        mc_we    <= 1'b0;
                        mc_mask  <= 2'b11;
                        mc_addr  <= if_addr;
                        mc_wdata <= '0;
                        resp_mem <= 1'b0;
                    end
                end
                S_GRANT_IF, S_WAIT_IF: begin
                    if (flush)
                        discard <= 1'b1;
                    if (state == S_WAIT_IF && mc_done)
                        rdata_q <= mc_we ? '0 : mc_rdata;
                end
                S_WAIT_MEM: begin
                    if (mc_done)
                        rdata_q <= mc_we ? '0 : mc_rdata;
                end
                S_RESP: begin
                    if (if_done)
                        if_inst_q <= rdata_q;
                    if (mem_done)
                        mem_rdata_q <= rdata_q;
                    discard <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios followed by randomized transactions. A
// small memory-controller model serves the DUT; expected results come from a
// separate reference memory updated from the requester-side inputs.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, rdy_in, flush;
    logic          if_req, if_done;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_inst;
    logic          mem_req, mem_we, mem_done;
    logic [1:0]    mem_mask;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mc_req, mc_we, mc_done;
    logic [1:0]    mc_mask;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_wdata, mc_rdata;
    logic          stall_if, stall_mem;

    int n_tests    = 0;
    int n_fail     = 0;
    int req_pulses = 0;

    logic [DW-1:0] ctrl_mem [logic [AW-1:0]];   // what the controller model holds
    logic [DW-1:0] ref_mem  [logic [AW-1:0]];   // what the requesters expect
    logic [DW-1:0] last_if  = '0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .mc_req(mc_req), .mc_we(mc_we), .mc_mask(mc_mask), .mc_addr(mc_addr),
        .mc_wdata(mc_wdata), .mc_done(mc_done), .mc_rdata(mc_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    // Count issue pulses mid-cycle, away from the active edge.
    always @(negedge clk) if (mc_req === 1'b1) req_pulses++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [DW-1:0] ctrl_rd(input logic [AW-1:0] a);
        return ctrl_mem.exists(a) ? ctrl_mem[a] : dflt(a);
    endfunction

    function automatic logic [DW-1:0] mask_w(input logic [1:0] m, input logic [DW-1:0] w);
        if (m == 2'b01) return w & 32'h0000_00ff;
        if (m == 2'b10) return w & 32'h0000_ffff;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
        n_tests++;
        assert (got === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Controller model: find the issue pulse, check the latched request, hold for lat cycles, then complete.
    task automatic ctrl_serve(input string tag, input int lat, input int flush_at, input bit stray,
                              input bit exp_we, input logic [1:0] exp_mask, input logic [AW-1:0] exp_addr,
                              input logic [DW-1:0] exp_wdata, input bit chk_wd);
        int n = 0;
        while (mc_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " mc_req"}, mc_req, 1'b1);
        chk({tag, " mc_addr"}, mc_addr, exp_addr);
        chk({tag, " mc_we/mask"}, {mc_we, mc_mask}, {exp_we, exp_mask});
        if (chk_wd) chk({tag, " mc_wdata"}, mc_wdata, exp_wdata);
        if (stray) begin
            mc_done  = 1'b1;
            mc_rdata = $urandom;
        end
        for (int i = 0; i < lat; i++) begin
            if (i == flush_at) begin
                flush  = 1'b1;
                if_req = 1'b0;
            end
            step();
            mc_done = 1'b0;
            flush   = 1'b0;
            chk({tag, " wait"}, {mc_req, if_done, mem_done, mc_addr}, {3'b000, exp_addr});
            chk({tag, " stall"}, {stall_if, stall_mem}, {if_req, mem_req && (mem_mask != 2'b00)});
        end
        mc_done  = 1'b1;
        mc_rdata = exp_we ? $urandom : ctrl_rd(mc_addr);
        if (exp_we) ctrl_mem[mc_addr] = mc_wdata;
        step();
        mc_done  = 1'b0;
        mc_rdata = $urandom;
    endtask

    task automatic finish_if(input string tag, input logic [DW-1:0] exp_d);
        chk({tag, " if_done"}, {if_done, mem_done, stall_if}, 3'b100);
        chk({tag, " if_inst"}, if_inst, exp_d);
        if_req = 1'b0;
        step();
        chk({tag, " if held"}, {if_done, if_inst}, {1'b0, exp_d});
        last_if = exp_d;
    endtask

    task automatic finish_mem(input string tag, input logic [DW-1:0] exp_d);
        chk({tag, " mem_done"}, {mem_done, if_done, stall_mem}, 3'b100);
        chk({tag, " mem_rdata"}, mem_rdata, exp_d);
        mem_req = 1'b0;
        step();
        chk({tag, " mem held"}, {mem_done, mem_rdata}, {1'b0, exp_d});
    endtask

    task automatic txn(input string tag, input bit is_mem, input bit we, input logic [1:0] mask,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int lat);
        int p0;
        logic [DW-1:0] exp_d;
        p0 = req_pulses;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_mask = mask; mem_addr = addr; mem_wdata = wdata;
            exp_d = we ? '0 : ref_rd(addr);
            ctrl_serve(tag, lat, -1, 1'b0, we, mask, addr, mask_w(mask, wdata), 1'b1);
            finish_mem(tag, exp_d);
            if (we) ref_mem[addr] = mask_w(mask, wdata);
        end else begin
            if_req = 1'b1; if_addr = addr;
            exp_d = ref_rd(addr);
            ctrl_serve(tag, lat, -1, 1'b0, 1'b0, 2'b11, addr, '0, 1'b0);
            finish_if(tag, exp_d);
        end
        chk({tag, " pulses"}, req_pulses - p0, 1);
    endtask

    initial begin
        int            p0;
        bit            r_mem, r_we;
        logic [1:0]    r_mask;
        logic [AW-1:0] r_addr;
        logic [DW-1:0] r_wd;
        int            r_lat;

        rst = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_mask = 2'b00; mem_addr = '0; mem_wdata = '0;
        mc_done = 1'b0; mc_rdata = '0;

        // Reset values, while in reset and after release.
        step(); step();
        chk("reset ctl", {mc_req, mc_we, mc_mask, if_done, mem_done, stall_if, stall_mem}, 8'h00);
        chk("reset data", {mc_addr, mc_wdata}, 64'h0);
        chk("reset results", {if_inst, mem_rdata}, 64'h0);
        rst = 1'b0;
        step();
        chk("post reset", {mc_req, if_done, mem_done, mc_mask}, 5'b0);

        // A completion outside WAIT is ignored.
        mc_done = 1'b1; mc_rdata = 32'hdead_beef;
        step();
        mc_done = 1'b0;
        chk("stray idle done", {if_done, mem_done, mc_req}, 3'b000);

        // Basic fetch with 5-cycle controller latency.
        ctrl_mem[32'h1000] = 32'h0000_0013;
        ref_mem[32'h1000]  = 32'h0000_0013;
        txn("fetch", 1'b0, 1'b0, 2'b11, 32'h1000, '0, 5);

        // Simultaneous IF and MEM load: MEM wins, IF follows once mem_req drops.
        p0 = req_pulses;
        if_req = 1'b1; if_addr = 32'h1004;
        mem_req = 1'b1; mem_we = 1'b0; mem_mask = 2'b11; mem_addr = 32'h2000; mem_wdata = '0;
        ctrl_serve("sim mem", 2, -1, 1'b1, 1'b0, 2'b11, 32'h2000, '0, 1'b1);
        chk("sim stall_if", stall_if, 1'b1);
        finish_mem("sim mem", ref_rd(32'h2000));
        chk("sim mem first", req_pulses - p0, 1);
        ctrl_serve("sim if", 3, -1, 1'b0, 1'b0, 2'b11, 32'h1004, '0, 1'b0);
        finish_if("sim if", ref_rd(32'h1004));
        chk("sim pulses", req_pulses - p0, 2);

        // Byte store: data forced to zero on mem_rdata.
        txn("store", 1'b1, 1'b1, 2'b01, 32'h0003_0000, 32'h0000_0041, 2);

        // Flush during WAIT_IF: transfer completes, result dropped.
        p0 = req_pulses;
        if_req = 1'b1; if_addr = 32'h1008;
        ctrl_serve("flush", 4, 1, 1'b0, 1'b0, 2'b11, 32'h1008, '0, 1'b0);
        chk("flush resp", {if_done, if_inst}, {1'b0, last_if});
        step();
        chk("flush idle", {if_done, if_inst, mc_req}, {1'b0, last_if, 1'b0});
        chk("flush pulses", req_pulses - p0, 1);
        txn("post flush", 1'b0, 1'b0, 2'b11, 32'h100c, '0, 2);

        // Flush in IDLE blocks the fetch grant for that cycle only.
        p0 = req_pulses;
        if_req = 1'b1; if_addr = 32'h1010; flush = 1'b1;
        step();
        chk("idle flush no grant", mc_req, 1'b0);
        flush = 1'b0;
        step();
        chk("idle flush then grant", mc_req, 1'b1);
        ctrl_serve("idle flush", 1, -1, 1'b0, 1'b0, 2'b11, 32'h1010, '0, 1'b0);
        finish_if("idle flush", ref_rd(32'h1010));
        chk("idle flush pulses", req_pulses - p0, 1);

        // rdy_in low for 3 cycles in GRANT_MEM: no pulse while low, exactly one afterwards.
        mem_req = 1'b1; mem_we = 1'b0; mem_mask = 2'b11; mem_addr = 32'h4000; mem_wdata = '0;
        p0 = req_pulses;
        step();
        rdy_in = 1'b0;
        #1;
        chk("rdy low", mc_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rdy frozen", {mc_req, mem_done, mc_addr}, {2'b00, 32'h4000});
        end
        rdy_in = 1'b1;
        #1;
        ctrl_serve("rdy", 2, -1, 1'b0, 1'b0, 2'b11, 32'h4000, '0, 1'b1);
        finish_mem("rdy", ref_rd(32'h4000));
        chk("rdy pulses", req_pulses - p0, 1);

        // Reset in WAIT_MEM: everything returns to zero and a late completion is ignored.
        mem_req = 1'b1; mem_we = 1'b0; mem_mask = 2'b11; mem_addr = 32'h5000;
        step();
        chk("rst grant", mc_req, 1'b1);
        step();
        rst = 1'b1; mem_req = 1'b0;
        step();
        rst = 1'b0;
        chk("rst ctl", {mc_req, mc_we, mc_mask, if_done, mem_done, stall_if, stall_mem}, 8'h00);
        chk("rst data", {mc_addr, mc_wdata}, 64'h0);
        chk("rst results", {if_inst, mem_rdata}, 64'h0);
        last_if = '0;
        step();
        mc_done = 1'b1; mc_rdata = 32'h1234_5678;
        step();
        mc_done = 1'b0;
        chk("rst late done", {mem_done, if_done, mem_rdata}, 34'h0);
        step();
        chk("rst late done 2", {mem_done, mc_req}, 2'b00);

        // Randomized mix of fetches, loads and stores over a small address pool.
        for (int k = 0; k < 40; k++) begin
            r_mem  = 1'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_mask = 2'($urandom_range(1, 3));
            r_addr = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            r_wd   = $urandom;
            r_lat  = $urandom_range(1, 4);
            txn($sformatf("rnd%0d", k), r_mem, r_we, r_mem ? r_mask : 2'b11, r_addr, r_wd, r_lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-serial RAM port of the memory controller between instruction fetch (IF) and the load/store stage (MEM). It latches one request at a time, issues it downstream with a one-cycle request pulse, waits for completion and returns the result to the originating requester with a one-cycle done pulse. It also produces per-requester stall requests for the stall controller, and discards in-flight instruction fetches on a pipeline flush.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data/instruction width

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- rdy_in  in  1  global ready; low freezes the block
- flush  in  1  pipeline flush; discards the in-flight or pending IF request
- if_req  in  1  IF request; held high until if_done
- if_addr  in  ADDR_W  fetch address (pc)
- if_done  out  1  one-cycle pulse; if_inst valid
- if_inst  out  DATA_W  fetched instruction; held until next if_done
- mem_req  in  1  MEM request; held high until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_mask  in  2  01 byte, 10 half, 11 word; 00 = no request
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data; bits above mask width ignored
- mem_done  out  1  one-cycle pulse; mem_rdata valid on loads
- mem_rdata  out  DATA_W  load data; 0 after a store; held until next mem_done
- mc_req  out  1  one-cycle issue pulse to the memory controller
- mc_we, mc_mask, mc_addr, mc_wdata  out  1/2/ADDR_W/DATA_W  latched request; stable from mc_req until mc_done
- mc_done  in  1  one-cycle completion pulse from the memory controller
- mc_rdata  in  DATA_W  read data, valid with mc_done
- stall_if  out  1  IF request pending and not yet done
- stall_mem  out  1  MEM request pending and not yet done

## Operation
- States: IDLE, GRANT_IF, WAIT_IF, GRANT_MEM, WAIT_MEM, RESP.
- IDLE: MEM has fixed priority. A valid MEM request (mem_req=1, mem_mask!=00) latches the mem_* fields, then next state is GRANT_MEM. Otherwise, if_req=1 with flush=0 latches if_addr (mc_mask=11, mc_we=0), then next state is GRANT_IF.
- GRANT_x: mc_req=1 for this cycle only, then WAIT_x.
- WAIT_x: hold all mc_* stable. On mc_done, capture mc_rdata (forced to 0 for stores), then RESP.
- RESP: assert the done pulse of the granted requester for exactly one cycle, then IDLE. New requests are not sampled in RESP, so a requester that drops req on seeing done is never serviced twice.
- Flush:
  - Asserted in GRANT_IF, WAIT_IF or RESP-for-IF: set a discard flag. The downstream transfer still completes, but if_done stays 0 and if_inst keeps its old value.
  - Asserted in IDLE: IF is not granted that cycle.
  - No effect on MEM transactions.
- stall_if = if_req & ~if_done. stall_mem = mem_req & (mem_mask!=00) & ~mem_done. Both are combinational.
- rdy_in=0: the FSM, latches and discard flag hold their values. mc_req, if_done and mem_done are forced to 0, and mc_done is ignored. A GRANT state re-pulses mc_req once rdy_in returns.
- Reset, including mid-transaction: state goes to IDLE, the discard flag clears, and all outputs go to 0. The memory controller shares rst, so no transfer survives.

## Timing
- Reset values: if_done=0, if_inst=0, mem_done=0, mem_rdata=0, mc_req=0, mc_we=0, mc_mask=00, mc_addr=0, mc_wdata=0.
- Request sampled at edge N (IDLE) → mc_req high during cycle N+1 → mc_done in cycle M → done pulse in cycle M+1 → IDLE in cycle M+2. Arbiter overhead is 3 cycles beyond the controller's latency.
- If if_req and mem_req are high together in IDLE, MEM wins. IF is granted in the IDLE cycle after MEM's RESP, provided mem_req has dropped.
- An mc_done that arrives outside WAIT_x is ignored.

## Test plan
- Reset, then IF fetch: if_req=1, if_addr=0x1000, with mc_done 5 cycles after mc_req and mc_rdata=0x00000013 → exactly one mc_req pulse with mc_addr=0x1000 and mc_mask=11; if_done pulses one cycle later with if_inst=0x00000013; stall_if is high until that pulse.
- Simultaneous requests: if_req and a load (mem_mask=11, mem_addr=0x2000) in the same IDLE cycle → mc_addr=0x2000 is issued first and mem_done arrives before any IF grant; IF is then issued at 0x1004.
- Store: mem_we=1, mem_mask=01, mem_addr=0x30000, mem_wdata=0x41 → mc_we=1, mc_mask=01, mc_wdata=0x41; mem_done pulses with mem_rdata=0.
- Flush during WAIT_IF → mc_done is consumed, if_done never pulses, and if_inst is unchanged; the next if_req is granted normally.
- rdy_in low for 3 cycles during GRANT_MEM → no mc_req while low, exactly one mc_req after rdy_in rises, and the address is unchanged.
- rst asserted in WAIT_MEM → the next cycle shows IDLE with all outputs 0, and a later mc_done produces no mem_done.
